// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and widths for the ALU issue controller slice.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 4;
  localparam int unsigned OP_W       = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_SHL = 3'b101;
  localparam logic [OP_W-1:0] OP_SHR = 3'b110;
  localparam logic [OP_W-1:0] OP_NOT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Only add/sub update the sticky carry flag.
  function automatic logic op_sets_carry(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction request and result response handshakes of the issue controller.
interface alu_issue_ctrl_if
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned AW     = 2
);

  logic              instr_valid;
  logic              instr_ready;
  logic [OP_W-1:0]   instr_op;
  logic [AW-1:0]     instr_rd;
  logic [AW-1:0]     instr_rs1;
  logic [AW-1:0]     instr_rs2;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [AW-1:0]     res_rd;
  logic              res_carry;

  // Upstream issuer / downstream consumer side.
  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, res_ready,
    input  instr_ready, res_valid, res_data, res_rd, res_carry
  );

  // Controller side.
  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, res_ready,
    output instr_ready, res_valid, res_data, res_rd, res_carry
  );

endinterface

// File: rtl/alu_regfile.sv
// Operand register file: two async read ports, host and writeback write ports.
module alu_regfile #(
  parameter  int unsigned DATA_W = 4,
  parameter  int unsigned NREGS  = 4,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              host_we,
  input  logic [AW-1:0]     host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  logic [DATA_W-1:0] mem [NREGS];

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];

  // Writeback is assigned last so it wins an address collision with the host.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      if (host_we) mem[host_addr] <= host_data;
      if (wb_we)   mem[wb_addr]   <= wb_data;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer around an external combinational ALU.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter  int unsigned DATA_W = ALU_DATA_W,
  parameter  int unsigned NREGS  = 4,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  alu_issue_ctrl_if.slave   bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              carry_flag
);

  state_t            state, next_state;
  logic              accept_c;
  logic              ready_q, valid_q;
  logic [AW-1:0]     rd_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_carry_q;
  logic [DATA_W-1:0] rs1_val, rs2_val;

  alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra1       (bus.instr_rs1),
    .ra2       (bus.instr_rs2),
    .rd1       (rs1_val),
    .rd2       (rs2_val),
    .host_we   (wr_en),
    .host_addr (wr_addr),
    .host_data (wr_data),
    .wb_we     (state == EXEC),
    .wb_addr   (rd_q),
    .wb_data   (alu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    case (state)
      IDLE: if (bus.instr_valid && ready_q) begin
        accept_c   = 1'b1;
        next_state = EXEC;
      end
      EXEC: next_state = RESP;
      RESP: if (bus.res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake flags are flops so both stay low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      ready_q <= (next_state == IDLE);
      valid_q <= (next_state == RESP);
    end
  end

  // Operand issue: sampled from the register file only on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      rd_q    <= '0;
    end else if (accept_c) begin
      alu_a   <= rs1_val;
      alu_b   <= rs2_val;
      alu_sel <= bus.instr_op;
      rd_q    <= bus.instr_rd;
    end
  end

  // Result capture at the closing edge of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      carry_flag  <= 1'b0;
    end else if (state == EXEC) begin
      res_data_q  <= alu_result;
      res_carry_q <= alu_carry;
      if (op_sets_carry(alu_sel)) carry_flag <= alu_carry;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.res_valid   = valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_rd      = rd_q;
  assign bus.res_carry   = res_carry_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a result scoreboard.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int unsigned DW = 4;
  localparam int unsigned AW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] rd;
    logic          carry;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [2:0]    alu_sel;
  logic          alu_carry, carry_flag;
  logic [DW:0]   wide;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  alu_issue_ctrl_if #(.DATA_W(DW), .AW(AW)) bus ();

  alu_issue_ctrl #(.DATA_W(DW), .NREGS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .carry_flag (carry_flag)
  );

  always #5 clk = ~clk;

  // Reference 4-bit ALU; sub carry is the borrow, shifts carry out the lost bit.
  always_comb begin
    wide = '0;
    case (alu_sel)
      OP_ADD:  wide = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:  wide = {1'b0, alu_a} - {1'b0, alu_b};
      OP_AND:  wide = {1'b0, alu_a & alu_b};
      OP_OR:   wide = {1'b0, alu_a | alu_b};
      OP_XOR:  wide = {1'b0, alu_a ^ alu_b};
      OP_SHL:  wide = {alu_a, 1'b0};
      OP_SHR:  wide = {alu_a[0], 1'b0, alu_a[DW-1:1]};
      OP_NOT:  wide = {1'b0, ~alu_a};
      default: wide = '0;
    endcase
    alu_result = wide[DW-1:0];
    alu_carry  = wide[DW];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted result is popped and compared.
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(bus.res_valid), 32'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_data",  32'(bus.res_data),  32'(e.data));
        check("res_rd",    32'(bus.res_rd),    32'(e.rd));
        check("res_carry", 32'(bus.res_carry), 32'(e.carry));
      end
    end
  end

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Issue one instruction; returns at posedge+1 of the EXEC cycle.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, rs1, rs2,
                       input logic [DW-1:0] ea, eb, ed, input logic ec, input bit push);
    bit   got;
    exp_t e;
    got = 1'b0;
    if (push) begin
      e.data = ed; e.rd = rd; e.carry = ec;
      exp_q.push_back(e);
    end
    bus.instr_valid = 1'b1; bus.instr_op = op;
    bus.instr_rd = rd; bus.instr_rs1 = rs1; bus.instr_rs2 = rs2;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.instr_ready) got = 1'b1;
    end
    if (!got) check("issue_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    check("alu_a",   32'(alu_a),   32'(ea));
    check("alu_b",   32'(alu_b),   32'(eb));
    check("alu_sel", 32'(alu_sel), 32'(op));
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && bus.instr_ready) done = 1'b1;
    end
    if (!done) check("idle_timeout", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    bus.instr_valid = 1'b0; bus.instr_op = '0; bus.instr_rd = '0;
    bus.instr_rs1 = '0; bus.instr_rs2 = '0; bus.res_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("rst_instr_ready", 32'(bus.instr_ready), 32'(0));
    check("rst_res_valid",   32'(bus.res_valid),   32'(0));
    check("rst_alu_a",       32'(alu_a),           32'(0));
    check("rst_carry_flag",  32'(carry_flag),      32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(bus.instr_ready), 32'(1));

    // Basic add; result must be valid two edges after acceptance.
    host_write(2'd1, 4'b0101);
    host_write(2'd2, 4'b0011);
    issue(OP_ADD, 2'd0, 2'd1, 2'd2, 4'b0101, 4'b0011, 4'b1000, 1'b0, 1'b1);
    check("exec_ready_low", 32'(bus.instr_ready), 32'(0));
    @(posedge clk); #1;
    check("latency_valid", 32'(bus.res_valid), 32'(1));
    wait_idle();
    check("flag_add_nc", 32'(carry_flag), 32'(0));
    issue(OP_OR, 2'd0, 2'd0, 2'd0, 4'b1000, 4'b1000, 4'b1000, 1'b0, 1'b1);
    wait_idle();

    // Carry-producing add, then xor leaves the flag untouched.
    host_write(2'd1, 4'b1100);
    host_write(2'd2, 4'b0101);
    issue(OP_ADD, 2'd3, 2'd1, 2'd2, 4'b1100, 4'b0101, 4'b0001, 1'b1, 1'b1);
    wait_idle();
    check("flag_add_c", 32'(carry_flag), 32'(1));
    issue(OP_XOR, 2'd3, 2'd1, 2'd2, 4'b1100, 4'b0101, 4'b1001, 1'b0, 1'b1);
    wait_idle();
    check("flag_after_xor", 32'(carry_flag), 32'(1));

    // Backpressure: response held stable while res_ready is low.
    bus.res_ready = 1'b0;
    issue(OP_AND, 2'd0, 2'd1, 2'd2, 4'b1100, 4'b0101, 4'b0100, 1'b0, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.res_valid),   32'(1));
      check("hold_data",  32'(bus.res_data),    32'(4'b0100));
      check("hold_rd",    32'(bus.res_rd),      32'(0));
      check("hold_ready", 32'(bus.instr_ready), 32'(0));
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", 32'(bus.res_valid),   32'(0));
    check("release_ready", 32'(bus.instr_ready), 32'(1));

    // Dependent pair: shr must see the shl writeback in r1.
    host_write(2'd1, 4'b0111);
    issue(OP_SHL, 2'd1, 2'd1, 2'd1, 4'b0111, 4'b0111, 4'b1110, 1'b0, 1'b1);
    wait_idle();
    issue(OP_SHR, 2'd2, 2'd1, 2'd2, 4'b1110, 4'b0101, 4'b0111, 1'b0, 1'b1);
    wait_idle();

    // Host write and writeback to r0 on the same edge: writeback wins.
    host_write(2'd1, 4'b0001);
    host_write(2'd2, 4'b0001);
    issue(OP_ADD, 2'd0, 2'd1, 2'd2, 4'b0001, 4'b0001, 4'b0010, 1'b0, 1'b1);
    host_write(2'd0, 4'b1111);
    wait_idle();
    issue(OP_OR, 2'd0, 2'd0, 2'd0, 4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b1);
    wait_idle();

    // Reset during EXEC discards the instruction and clears all state.
    host_write(2'd1, 4'b1111);
    issue(OP_ADD, 2'd3, 2'd1, 2'd2, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1);
    wait_idle();
    check("flag_before_rst", 32'(carry_flag), 32'(1));
    issue(OP_SUB, 2'd3, 2'd1, 2'd2, 4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    check("mid_rst_valid", 32'(bus.res_valid),   32'(0));
    check("mid_rst_ready", 32'(bus.instr_ready), 32'(0));
    check("mid_rst_flag",  32'(carry_flag),      32'(0));
    check("mid_rst_alu_b", 32'(alu_b),           32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rel_ready_low", 32'(bus.instr_ready), 32'(0));
    @(posedge clk); #1;
    check("rel_ready_high", 32'(bus.instr_ready), 32'(1));
    check("rel_valid",      32'(bus.res_valid),   32'(0));
    issue(OP_ADD, 2'd0, 2'd1, 2'd2, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    wait_idle();
    issue(OP_OR, 2'd3, 2'd3, 2'd3, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    wait_idle();
    check("final_flag", 32'(carry_flag), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
